// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: shares one 16-bit word memory port between
// the A-bus cart engine (port A, fixed priority) and the HPS backup-save
// channel (port B, gated by B_EN, protected by a starvation guard).
// Ports:
//   CLK, RST_N              clock, asynchronous active-low reset
//   B_EN                    port B enable
//   A_A/A_DO/A_WE/A_RD      port A request (level), A_DI/A_RDY response
//   B_A/B_DO/B_WE/B_RD      port B request (level), B_DI/B_RDY response
//   MEM_A/MEM_DO/MEM_WE/MEM_RD  registered memory request
//   MEM_DI/MEM_RDY          memory read data and completion pulse
// One transaction is outstanding at a time.  A one-cycle DONE state
// follows every completion so the finishing requester can drop its
// still-high request before the next arbitration.

module cart_mem_arbiter #(
    parameter int A_BURST_MAX = 4,
    parameter int AW          = 25
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          B_EN,
    input  logic [AW-1:0] A_A,
    input  logic [15:0]   A_DO,
    input  logic [1:0]    A_WE,
    input  logic          A_RD,
    output logic [15:0]   A_DI,
    output logic          A_RDY,
    input  logic [AW-1:0] B_A,
    input  logic [15:0]   B_DO,
    input  logic [1:0]    B_WE,
    input  logic          B_RD,
    output logic [15:0]   B_DI,
    output logic          B_RDY,
    output logic [AW-1:0] MEM_A,
    output logic [15:0]   MEM_DO,
    output logic [1:0]    MEM_WE,
    output logic          MEM_RD,
    input  logic [15:0]   MEM_DI,
    input  logic          MEM_RDY
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_A = 2'd1;
    localparam logic [1:0] BUSY_B = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int BW = $clog2(A_BURST_MAX + 1);

    logic [1:0]    state_q,  state_d;
    logic [AW-1:0] mem_a_q,  mem_a_d;
    logic [15:0]   mem_do_q, mem_do_d;
    logic [1:0]    mem_we_q, mem_we_d;
    logic          mem_rd_q, mem_rd_d;
    logic [15:0]   a_di_q,   a_di_d;
    logic [15:0]   b_di_q,   b_di_d;
    logic          a_rdy_q,  a_rdy_d;
    logic          b_rdy_q,  b_rdy_d;
    logic [BW-1:0] burst_q,  burst_d;

    logic a_req;
    logic b_pend;
    logic burst_max;
    logic grant_a;
    logic grant_b;

    assign a_req     = A_RD || (A_WE != 2'b00);
    assign b_pend    = B_EN && (B_RD || (B_WE != 2'b00));
    assign burst_max = (burst_q >= BW'(A_BURST_MAX));

    // A wins unless B has waited out a full burst of A grants.
    assign grant_a = a_req && !(b_pend && burst_max);
    assign grant_b = b_pend && (!a_req || burst_max);

    always_comb begin
        state_d  = state_q;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        mem_we_d = mem_we_q;
        mem_rd_d = mem_rd_q;
        a_di_d   = a_di_q;
        b_di_d   = b_di_q;
        a_rdy_d  = 1'b0;
        b_rdy_d  = 1'b0;
        // The guard only counts while B is actually waiting.
        burst_d  = b_pend ? burst_q : '0;

        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    mem_a_d  = A_A;
                    mem_do_d = A_DO;
                    mem_we_d = A_WE;
                    mem_rd_d = A_RD && (A_WE == 2'b00);
                    state_d  = BUSY_A;
                    if (b_pend && !burst_max) begin
                        burst_d = burst_q + BW'(1);
                    end
                end else if (grant_b) begin
                    mem_a_d  = B_A;
                    mem_do_d = B_DO;
                    mem_we_d = B_WE;
                    mem_rd_d = B_RD && (B_WE == 2'b00);
                    state_d  = BUSY_B;
                    burst_d  = '0;
                end
            end
            BUSY_A: begin
                if (MEM_RDY) begin
                    if (mem_rd_q) begin
                        a_di_d = MEM_DI;
                    end
                    a_rdy_d  = 1'b1;
                    mem_rd_d = 1'b0;
                    mem_we_d = 2'b00;
                    state_d  = DONE;
                end
            end
            BUSY_B: begin
                if (MEM_RDY) begin
                    if (mem_rd_q) begin
                        b_di_d = MEM_DI;
                    end
                    b_rdy_d  = 1'b1;
                    mem_rd_d = 1'b0;
                    mem_we_d = 2'b00;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            mem_a_q  <= '0;
            mem_do_q <= '0;
            mem_we_q <= '0;
            mem_rd_q <= 1'b0;
            a_di_q   <= '0;
            b_di_q   <= '0;
            a_rdy_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            mem_a_q  <= mem_a_d;
            mem_do_q <= mem_do_d;
            mem_we_q <= mem_we_d;
            mem_rd_q <= mem_rd_d;
            a_di_q   <= a_di_d;
            b_di_q   <= b_di_d;
            a_rdy_q  <= a_rdy_d;
            b_rdy_q  <= b_rdy_d;
            burst_q  <= burst_d;
        end
    end

    assign MEM_A  = mem_a_q;
    assign MEM_DO = mem_do_q;
    assign MEM_WE = mem_we_q;
    assign MEM_RD = mem_rd_q;
    assign A_DI   = a_di_q;
    assign B_DI   = b_di_q;
    assign A_RDY  = a_rdy_q;
    assign B_RDY  = b_rdy_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: table of single transactions
// plus directed sequences for burst guard, B_EN gating, reset and spurious RDY.

module tb_cart_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        B_EN = 1'b0;
    logic [24:0] A_A = '0;
    logic [15:0] A_DO = '0;
    logic [1:0]  A_WE = '0;
    logic        A_RD = 1'b0;
    logic [15:0] A_DI;
    logic        A_RDY;
    logic [24:0] B_A = '0;
    logic [15:0] B_DO = '0;
    logic [1:0]  B_WE = '0;
    logic        B_RD = 1'b0;
    logic [15:0] B_DI;
    logic        B_RDY;
    logic [24:0] MEM_A;
    logic [15:0] MEM_DO;
    logic [1:0]  MEM_WE;
    logic        MEM_RD;
    logic [15:0] MEM_DI = 16'hDEAD;
    logic        MEM_RDY = 1'b0;

    int checks = 0;
    int failures = 0;

    cart_mem_arbiter #(.A_BURST_MAX(4), .AW(25)) dut (
        .CLK(CLK), .RST_N(RST_N), .B_EN(B_EN),
        .A_A(A_A), .A_DO(A_DO), .A_WE(A_WE), .A_RD(A_RD),
        .A_DI(A_DI), .A_RDY(A_RDY),
        .B_A(B_A), .B_DO(B_DO), .B_WE(B_WE), .B_RD(B_RD),
        .B_DI(B_DI), .B_RDY(B_RDY),
        .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE),
        .MEM_RD(MEM_RD), .MEM_DI(MEM_DI), .MEM_RDY(MEM_RDY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        port_b;
        logic [24:0] addr;
        logic [15:0] wdata;
        logic [1:0]  we;
        logic        rd;
        logic [15:0] mem_di;
        int          lat;
        logic [1:0]  exp_we;
        logic        exp_rd;
        logic [15:0] exp_di;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        A_RD = 1'b0; A_WE = 2'b00; A_DO = '0;
        B_RD = 1'b0; B_WE = 2'b00; B_DO = '0;
    endtask

    task automatic do_txn(input vec_t v);
        logic held;
        @(negedge CLK);
        if (v.port_b) begin
            B_EN = 1'b1; B_A = v.addr; B_DO = v.wdata;
            B_WE = v.we; B_RD = v.rd;
        end else begin
            A_A = v.addr; A_DO = v.wdata; A_WE = v.we; A_RD = v.rd;
        end
        @(negedge CLK);
        chk("mem_a", 32'(MEM_A), 32'(v.addr));
        chk("mem_do", 32'(MEM_DO), 32'(v.wdata));
        chk("mem_we", 32'(MEM_WE), 32'(v.exp_we));
        chk("mem_rd", 32'(MEM_RD), 32'(v.exp_rd));
        held = 1'b1;
        for (int i = 1; i <= v.lat; i++) begin
            if (i > 1) @(negedge CLK);
            if (MEM_RD !== v.exp_rd || MEM_WE !== v.exp_we) held = 1'b0;
            if (A_RDY || B_RDY) held = 1'b0;
            if (i == v.lat) begin
                MEM_DI = v.mem_di;
                MEM_RDY = 1'b1;
            end
        end
        chk("strobe_held", 32'(held), 32'd1);
        @(negedge CLK);
        MEM_RDY = 1'b0;
        MEM_DI = 16'hDEAD;
        chk("rdy_own", 32'(v.port_b ? B_RDY : A_RDY), 32'd1);
        chk("rdy_other", 32'(v.port_b ? A_RDY : B_RDY), 32'd0);
        chk("strobe_off", 32'({MEM_RD, MEM_WE}), 32'd0);
        chk("di", 32'(v.port_b ? B_DI : A_DI), 32'(v.exp_di));
        drop_reqs();
        @(negedge CLK);
        chk("rdy_pulse_end", 32'({A_RDY, B_RDY}), 32'd0);
        chk("di_hold", 32'(v.port_b ? B_DI : A_DI), 32'(v.exp_di));
    endtask

    initial begin
        logic [9:0] exp_order;
        logic       found;
        logic       seen;
        logic       both;

        //          b  addr          wdata     we     rd  mem_di   lat ewe   erd  exp_di
        tbl[0] = '{1'b0, 25'h0000123, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 3, 2'b00, 1'b1, 16'hBEEF};
        tbl[1] = '{1'b1, 25'h0000456, 16'h5A5A, 2'b01, 1'b0, 16'h7777, 2, 2'b01, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 25'h1ABCDEF, 16'h1234, 2'b11, 1'b1, 16'h7777, 1, 2'b11, 1'b0, 16'hBEEF};
        tbl[3] = '{1'b1, 25'h1FFFFFF, 16'h0000, 2'b00, 1'b1, 16'hCAFE, 1, 2'b00, 1'b1, 16'hCAFE};
        tbl[4] = '{1'b0, 25'h0000000, 16'hFFFF, 2'b10, 1'b0, 16'h7777, 5, 2'b10, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b0, 25'h0000777, 16'h0000, 2'b00, 1'b1, 16'h1357, 2, 2'b00, 1'b1, 16'h1357};

        #12;
        chk("rst_mem", 32'({MEM_RD, MEM_WE}), 32'd0);
        chk("rst_mem_a", 32'(MEM_A), 32'd0);
        chk("rst_rdy", 32'({A_RDY, B_RDY}), 32'd0);
        chk("rst_di", 32'({A_DI, B_DI}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_txn(tbl[i]);
        end

        // Spurious memory completion while idle.
        @(negedge CLK);
        MEM_RDY = 1'b1;
        @(negedge CLK);
        MEM_RDY = 1'b0;
        chk("spur_rdy", 32'({A_RDY, B_RDY}), 32'd0);
        chk("spur_strobe", 32'({MEM_RD, MEM_WE}), 32'd0);
        @(negedge CLK);
        chk("spur_rdy2", 32'({A_RDY, B_RDY}), 32'd0);

        // Burst guard: both ports reading continuously.
        exp_order = 10'b10_0001_0000;
        both = 1'b0;
        @(negedge CLK);
        A_A = 25'h0000010; B_A = 25'h0000020;
        A_RD = 1'b1; B_RD = 1'b1; B_EN = 1'b1;
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge CLK);
                if (A_RDY && B_RDY) both = 1'b1;
                if (MEM_RD) found = 1'b1;
            end
            chk("burst_found", 32'(found), 32'd1);
            chk($sformatf("burst_grant%0d", g),
                32'(MEM_A == 25'h0000020), 32'(exp_order[g]));
            MEM_RDY = 1'b1;
            @(negedge CLK);
            MEM_RDY = 1'b0;
            if (A_RDY && B_RDY) both = 1'b1;
        end
        chk("rdy_exclusive", 32'(both), 32'd0);
        drop_reqs();
        repeat (3) @(negedge CLK);

        // B_EN gating.
        B_EN = 1'b0; B_A = 25'h0000ABC; B_RD = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (MEM_RD || MEM_WE != 2'b00) seen = 1'b1;
        end
        chk("ben_blocked", 32'(seen), 32'd0);
        B_EN = 1'b1;
        @(negedge CLK);
        chk("ben_grant_rd", 32'(MEM_RD), 32'd1);
        chk("ben_grant_a", 32'(MEM_A), 32'h0000ABC);
        MEM_DI = 16'h2468;
        MEM_RDY = 1'b1;
        @(negedge CLK);
        MEM_RDY = 1'b0;
        chk("ben_rdy", 32'(B_RDY), 32'd1);
        chk("ben_di", 32'(B_DI), 32'h2468);
        drop_reqs();
        B_EN = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset in the middle of an A read.
        A_A = 25'h0000055; A_RD = 1'b1;
        @(negedge CLK);
        chk("rst_busy_rd", 32'(MEM_RD), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_async_rd", 32'(MEM_RD), 32'd0);
        chk("rst_async_a", 32'(MEM_A), 32'd0);
        chk("rst_async_di", 32'({A_DI, B_DI}), 32'd0);
        drop_reqs();
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (A_RDY || B_RDY || MEM_RD) seen = 1'b1;
        end
        chk("rst_no_pulse", 32'(seen), 32'd0);
        do_txn(tbl[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
